// File: rtl/tick_pwm.sv
// Tick-driven PWM generator with glitch-free period/duty reload at wrap.
// Optional macro TICK_PWM_PERIOD_CNT_EN adds a 16-bit period_start counter.
module tick_pwm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_duty,
    output logic             pwm_out,
    output logic             period_start
`ifdef TICK_PWM_PERIOD_CNT_EN
    ,
    output logic [15:0]      period_cnt
`endif
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_phase;
    logic [WIDTH-1:0] w_phase_nxt;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] w_period_nxt;
    logic [WIDTH-1:0] r_duty;
    logic [WIDTH-1:0] w_duty_nxt;
    logic             r_pend;
    logic             w_pend_nxt;
    logic [WIDTH-1:0] r_pend_period;
    logic [WIDTH-1:0] r_pend_duty;
    logic             r_pwm;
    logic             r_start;
    logic             w_start;
    logic             w_apply;
    logic             w_accept;

    // Only one config can wait; ready is simply "nothing pending".
    assign w_accept  = cfg_valid & ~r_pend;
    assign cfg_ready = ~r_pend;
    assign pwm_out      = r_pwm;
    assign period_start = r_start;

    // Next-state: phase advances only on tick, config loads only at a wrap.
    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_period_nxt = r_period;
        w_duty_nxt   = r_duty;
        w_start      = 1'b0;
        w_apply      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (tick && r_pend) begin
                    w_apply     = 1'b1;
                    w_state_nxt = S_RUN;
                    w_phase_nxt = '0;
                    w_start     = 1'b1;
                end
            end
            S_RUN: begin
                if (tick) begin
                    if (r_phase == r_period) begin
                        w_phase_nxt = '0;
                        w_start     = 1'b1;
                        w_apply     = r_pend;
                    end else begin
                        w_phase_nxt = r_phase + ONE;
                    end
                end
            end
        endcase
        if (w_apply) begin
            w_period_nxt = r_pend_period;
            w_duty_nxt   = r_pend_duty;
        end
        // Apply needs pending=1, accept needs pending=0: never both.
        if (w_apply) begin
            w_pend_nxt = 1'b0;
        end else if (w_accept) begin
            w_pend_nxt = 1'b1;
        end else begin
            w_pend_nxt = r_pend;
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_phase  <= '0;
            r_period <= '0;
            r_duty   <= '0;
            r_pend   <= 1'b0;
            r_pwm    <= 1'b0;
            r_start  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_phase  <= w_phase_nxt;
            r_period <= w_period_nxt;
            r_duty   <= w_duty_nxt;
            r_pend   <= w_pend_nxt;
            r_pwm    <= (w_state_nxt == S_RUN) &&
                        (w_phase_nxt < w_duty_nxt);
            r_start  <= w_start;
        end
    end

    // Capture the offered config on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_period <= '0;
            r_pend_duty   <= '0;
        end else if (w_accept) begin
            r_pend_period <= cfg_period;
            r_pend_duty   <= cfg_duty;
        end
    end

`ifdef TICK_PWM_PERIOD_CNT_EN
    logic [15:0] r_period_cnt;

    assign period_cnt = r_period_cnt;

    // Count period starts, wrapping naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period_cnt <= '0;
        end else if (w_start) begin
            r_period_cnt <= r_period_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tick_pwm.sv
// Directed self-checking bench for tick_pwm.
// Inputs change at negedge; outputs are checked at the following negedge.
module tb_tick_pwm;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_period;
    logic [7:0] cfg_duty;
    logic       pwm_out;
    logic       period_start;
`ifdef TICK_PWM_PERIOD_CNT_EN
    logic [15:0] period_cnt;
`endif

    int n_checks;
    int n_errors;

    tick_pwm #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_period   (cfg_period),
        .cfg_duty     (cfg_duty),
        .pwm_out      (pwm_out),
        .period_start (period_start)
`ifdef TICK_PWM_PERIOD_CNT_EN
        ,
        .period_cnt   (period_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, wait to the next negedge.
    task automatic cyc(input logic t, input logic v,
                       input logic [7:0] p, input logic [7:0] d);
        tick       = t;
        cfg_valid  = v;
        cfg_period = p;
        cfg_duty   = d;
        @(negedge clk);
    endtask

    // One tick followed by two idle clocks.
    task automatic t3(input logic epwm, input logic eps, input string tag);
        cyc(1'b1, 1'b0, 8'd0, 8'd0);
        chk({tag, "_pwm0"}, {15'd0, pwm_out}, {15'd0, epwm});
        chk({tag, "_ps0"}, {15'd0, period_start}, {15'd0, eps});
        cyc(1'b0, 1'b0, 8'd0, 8'd0);
        chk({tag, "_pwm1"}, {15'd0, pwm_out}, {15'd0, epwm});
        chk({tag, "_ps1"}, {15'd0, period_start}, 16'd0);
        cyc(1'b0, 1'b0, 8'd0, 8'd0);
        chk({tag, "_pwm2"}, {15'd0, pwm_out}, {15'd0, epwm});
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b0;
        tick       = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = 8'd0;
        cfg_duty   = 8'd0;

        // 1. async reset with no clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_pwm", {15'd0, pwm_out}, 16'd0);
        chk("rst_ps", {15'd0, period_start}, 16'd0);
        chk("rst_rdy", {15'd0, cfg_ready}, 16'd1);
`ifdef TICK_PWM_PERIOD_CNT_EN
        chk("rst_cnt", period_cnt, 16'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // tick in IDLE without config does nothing
        cyc(1'b1, 1'b0, 8'd0, 8'd0);
        chk("idle_ps", {15'd0, period_start}, 16'd0);
        chk("idle_pwm", {15'd0, pwm_out}, 16'd0);

        // 2. basic PWM P=3 D=2
        cyc(1'b0, 1'b1, 8'd3, 8'd2);
        chk("b_rdy_lo", {15'd0, cfg_ready}, 16'd0);
        chk("b_pwm_idle", {15'd0, pwm_out}, 16'd0);
        t3(1'b1, 1'b1, "b_ph0");
        chk("b_rdy_hi", {15'd0, cfg_ready}, 16'd1);
        t3(1'b1, 1'b0, "b_ph1");
        t3(1'b0, 1'b0, "b_ph2");
        t3(1'b0, 1'b0, "b_ph3");
        t3(1'b1, 1'b1, "b_wrap");

        // 4. handshake mid-period, second offer stalls
        cyc(1'b0, 1'b1, 8'd1, 8'd1);
        chk("h_rdy_lo", {15'd0, cfg_ready}, 16'd0);
        cyc(1'b0, 1'b1, 8'd7, 8'd7);
        chk("h_stall", {15'd0, cfg_ready}, 16'd0);
        t3(1'b1, 1'b0, "h_ph1");
        t3(1'b0, 1'b0, "h_ph2");
        t3(1'b0, 1'b0, "h_ph3");
        chk("h_rdy_pre", {15'd0, cfg_ready}, 16'd0);
        t3(1'b1, 1'b1, "h_new0");
        chk("h_rdy_post", {15'd0, cfg_ready}, 16'd1);
        t3(1'b0, 1'b0, "h_new1");
        t3(1'b1, 1'b1, "h_new_wrap");

        // 5. accept on the wrap cycle: old config runs one more period
        t3(1'b0, 1'b0, "s_ph1");
        cyc(1'b1, 1'b1, 8'd3, 8'd0);
        chk("s_wrap_pwm", {15'd0, pwm_out}, 16'd1);
        chk("s_wrap_ps", {15'd0, period_start}, 16'd1);
        chk("s_wrap_rdy", {15'd0, cfg_ready}, 16'd0);
        t3(1'b0, 1'b0, "s_old1");
        t3(1'b0, 1'b1, "s_apply");
        chk("s_rdy_post", {15'd0, cfg_ready}, 16'd1);

        // 3. D=0 stays low, then D=4 > P stays high through wrap
        cyc(1'b0, 1'b1, 8'd3, 8'd4);
        t3(1'b0, 1'b0, "d0_ph1");
        t3(1'b0, 1'b0, "d0_ph2");
        t3(1'b0, 1'b0, "d0_ph3");
        t3(1'b1, 1'b1, "d4_ph0");
        t3(1'b1, 1'b0, "d4_ph1");
        t3(1'b1, 1'b0, "d4_ph2");
        t3(1'b1, 1'b0, "d4_ph3");
        t3(1'b1, 1'b1, "d4_wrap");

        // 6. P=0 D=1 with continuous tick
        cyc(1'b0, 1'b1, 8'd0, 8'd1);
        t3(1'b1, 1'b0, "p0_pre1");
        t3(1'b1, 1'b0, "p0_pre2");
        t3(1'b1, 1'b0, "p0_pre3");
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 8'd0, 8'd0);
            chk("p0_ps", {15'd0, period_start}, 16'd1);
            chk("p0_pwm", {15'd0, pwm_out}, 16'd1);
        end
        cyc(1'b1, 1'b1, 8'd5, 8'd5);
        chk("p0_acc_rdy", {15'd0, cfg_ready}, 16'd0);
        chk("p0_acc_ps", {15'd0, period_start}, 16'd1);
        // reset mid-run before the edge that would apply it
        #2 rst = 1'b1;
        #1;
        chk("mrst_pwm", {15'd0, pwm_out}, 16'd0);
        chk("mrst_ps", {15'd0, period_start}, 16'd0);
        chk("mrst_rdy", {15'd0, cfg_ready}, 16'd1);
        tick      = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 8'd0, 8'd0);
            chk("post_ps", {15'd0, period_start}, 16'd0);
            chk("post_pwm", {15'd0, pwm_out}, 16'd0);
            chk("post_rdy", {15'd0, cfg_ready}, 16'd1);
        end

`ifdef TICK_PWM_PERIOD_CNT_EN
        // period counter wrap
        cyc(1'b0, 1'b1, 8'd0, 8'd1);
        chk("cnt_zero", period_cnt, 16'd0);
        cyc(1'b1, 1'b0, 8'd0, 8'd0);
        chk("cnt_one", period_cnt, 16'd1);
        for (int i = 0; i < 65534; i++) begin
            cyc(1'b1, 1'b0, 8'd0, 8'd0);
        end
        chk("cnt_max", period_cnt, 16'hFFFF);
        cyc(1'b1, 1'b0, 8'd0, 8'd0);
        chk("cnt_wrap", period_cnt, 16'd0);
        cyc(1'b0, 1'b0, 8'd0, 8'd0);
        chk("cnt_hold", period_cnt, 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
